mv_fetch: RTL and testbench
===========================

Name: mv_fetch

Overview:
- Read-side counterpart of the motion-vector store. Streams the stored per-block motion vectors (mvx, mvy) back out of the MV memory, one frame at a time, in raster block order.
- Issues synchronous reads to the MV memory, which has 1-cycle read latency.
- Delivers each vector with its block coordinates on a valid/ready stream to the motion-compensation consumer.
- A 2-entry output buffer absorbs consumer backpressure without losing any in-flight read.

Parameters:
- ADDR_W, 21, MV memory address width (matches the 2M-entry store).
- MV_W, 4, width of each vector component.
- BLK_COLS, 120, blocks per row (1920/16).
- BLK_ROWS, 68, block rows per frame (1088/16).
- CRD_W, 8, width of the block-coordinate outputs; must satisfy 2^CRD_W >= max(BLK_COLS, BLK_ROWS).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a frame fetch; ignored unless in IDLE.
- base_addr  in  ADDR_W  address of block (0,0); sampled when start is accepted.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last vector is accepted by the consumer.
- mem_rd_en  out  1  memory read strobe.
- mem_rd_addr  out  ADDR_W  memory read address.
- mem_rd_data  in  2*MV_W  read data {mvy, mvx}; valid the cycle after mem_rd_en.
- out_valid  out  1  output vector valid.
- out_ready  in  1  consumer ready.
- out_mvx  out  MV_W  motion vector x component.
- out_mvy  out  MV_W  motion vector y component.
- out_bx  out  CRD_W  block column.
- out_by  out  CRD_W  block row.
- out_last  out  1  high with the final vector of the frame (bx=BLK_COLS-1, by=BLK_ROWS-1).

Behaviour:
- Reset (async assert, sync deassert internally):
  - FSM enters IDLE.
  - busy, done, mem_rd_en, out_valid, out_last = 0.
  - All addresses, coordinates, buffer contents and counters = 0.
- FSM states:
  - IDLE:
    - start=1 -> RUN.
    - Latch base_addr into rd_ptr; clear issue counters ix=0, iy=0.
  - RUN:
    - Issue a read whenever credit allows; a read carries address rd_ptr and tag (ix, iy).
    - After each issue: rd_ptr += 1 (wraps modulo 2^ADDR_W); ix increments; at ix=BLK_COLS-1, ix wraps to 0 and iy increments.
    - After the read tagged (BLK_COLS-1, BLK_ROWS-1) is issued -> DRAIN.
  - DRAIN:
    - No further reads.
    - When the buffer is empty and no read is in flight -> DONE.
  - DONE:
    - done=1 for exactly one cycle; busy drops the same cycle -> IDLE.
- Credit rule: a read is issued in a cycle only if (buffer occupancy + in-flight reads) < 2, counting a pop occurring that same cycle.
  - Guarantees the buffer never overflows.
  - Gives full throughput (one vector per cycle) when out_ready is held high.
- Read return:
  - Data arrives one cycle after mem_rd_en.
  - Pushed into the buffer as {mvy, mvx} together with its delayed tag.
  - out_last is derived from the tag.
- Output:
  - out_valid = buffer non-empty; outputs show the head entry.
  - Pop when out_valid && out_ready.
  - Outputs must stay stable while out_valid=1 and out_ready=0.
  - Push and pop in the same cycle leave occupancy unchanged.
- Latency: start accepted at cycle T:
  - First mem_rd_en at T+1.
  - First out_valid at T+3 (data returns at T+2 and registers into the buffer).
- Width rules:
  - mem_rd_data[MV_W-1:0] is mvx; mem_rd_data[2*MV_W-1:MV_W] is mvy.
  - Vectors pass through unmodified (no sign extension).
- Boundary conditions:
  - start while busy: ignored; no restart, no state change.
  - BLK_COLS=1 or BLK_ROWS=1: the FSM must still terminate correctly.
  - rst_n asserted mid-frame: reads abort immediately and buffered data is discarded; the next start begins from block (0,0).
  - out_ready low indefinitely: at most 2 reads outstanding; mem_rd_en stays 0.

Test Plan:
- Full-rate frame: preload memory from base 0 with {mvy,mvx}=addr[7:0]; BLK_COLS=4, BLK_ROWS=3; out_ready=1; pulse start -> 12 vectors on consecutive cycles starting T+3. Block (2,1) carries data 0x06. out_last only on (3,2). done pulses one cycle after the final handshake.
- Backpressure: same frame with out_ready toggling 1,0,0,1 -> every vector delivered exactly once in raster order; outputs stable while stalled; never more than 2 reads outstanding.
- Address wrap: base_addr=2^21-2 -> reads at 0x1FFFFE, 0x1FFFFF, 0x000000, ... with correct coordinates.
- Start while busy: pulse start again mid-frame with base_addr=0x100 -> ignored; the frame completes from the original base; a single done pulse.
- Reset mid-frame: assert rst_n low after 5 accepted vectors -> all outputs 0 immediately. Then restart -> first vector is block (0,0).
- Degenerate 1x1 frame: BLK_COLS=BLK_ROWS=1 -> exactly one read, one vector with out_last=1, then done.

Source files
------------

// File: rtl/mv_fetch_if.sv
// Memory read port and vector output stream of the MV fetch engine.
interface mv_fetch_if #(
  parameter int unsigned ADDR_W = 21,
  parameter int unsigned MV_W   = 4,
  parameter int unsigned CRD_W  = 8
) ();
  logic                mem_rd_en;
  logic [ADDR_W-1:0]   mem_rd_addr;
  logic [2*MV_W-1:0]   mem_rd_data;
  logic                out_valid;
  logic                out_ready;
  logic [MV_W-1:0]     out_mvx;
  logic [MV_W-1:0]     out_mvy;
  logic [CRD_W-1:0]    out_bx;
  logic [CRD_W-1:0]    out_by;
  logic                out_last;

  modport master (
    output mem_rd_en, mem_rd_addr,
    input  mem_rd_data,
    output out_valid, out_mvx, out_mvy, out_bx, out_by, out_last,
    input  out_ready
  );

  modport slave (
    input  mem_rd_en, mem_rd_addr,
    output mem_rd_data,
    input  out_valid, out_mvx, out_mvy, out_bx, out_by, out_last,
    output out_ready
  );
endinterface

// File: rtl/mv_fetch.sv
// Streams one frame of stored motion vectors out of the MV memory in raster
// block order, through a 2-entry buffer on a valid/ready stream.
module mv_fetch #(
  parameter int unsigned ADDR_W   = 21,
  parameter int unsigned MV_W     = 4,
  parameter int unsigned BLK_COLS = 120,
  parameter int unsigned BLK_ROWS = 68,
  parameter int unsigned CRD_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  mv_fetch_if.master        bus
);

  localparam logic [CRD_W-1:0] LAST_X = CRD_W'(BLK_COLS - 1);
  localparam logic [CRD_W-1:0] LAST_Y = CRD_W'(BLK_ROWS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic [MV_W-1:0]  mvy;
    logic [MV_W-1:0]  mvx;
    logic [CRD_W-1:0] bx;
    logic [CRD_W-1:0] by;
    logic             last;
  } ent_t;

  state_t            state;
  logic [1:0]        rst_sync;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CRD_W-1:0]  ix;
  logic [CRD_W-1:0]  iy;
  logic              rd_vld;
  logic [CRD_W-1:0]  tag_x;
  logic [CRD_W-1:0]  tag_y;
  ent_t              buf_q [2];
  logic              head;
  logic              tail;
  logic [1:0]        occ;

  logic              pop;
  logic              issue;
  logic              last_tag;
  logic [2:0]        pend;
  ent_t              head_ent;

  // Reset release is synchronised; start is only honoured once it has settled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  // Credit check counts buffered entries, the read landing this cycle and
  // this cycle's pop; the read strobe is combinational so the same-cycle pop
  // can be credited, which is what sustains one vector per cycle.
  always_comb begin
    pop      = (occ != 2'd0) && bus.out_ready;
    pend     = 3'(occ) + 3'(rd_vld) - 3'(pop);
    issue    = (state == S_RUN) && (pend < 3'd2);
    last_tag = (ix == LAST_X) && (iy == LAST_Y);
    head_ent = buf_q[head];
  end

  assign bus.mem_rd_en   = issue;
  assign bus.mem_rd_addr = rd_ptr;
  assign bus.out_valid   = (occ != 2'd0);
  assign bus.out_mvx     = head_ent.mvx;
  assign bus.out_mvy     = head_ent.mvy;
  assign bus.out_bx      = head_ent.bx;
  assign bus.out_by      = head_ent.by;
  assign bus.out_last    = head_ent.last;

  // Read return: delay the tag alongside the memory latency and push into the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld   <= 1'b0;
      tag_x    <= '0;
      tag_y    <= '0;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      head     <= 1'b0;
      tail     <= 1'b0;
      occ      <= 2'd0;
    end else begin
      rd_vld <= issue;
      tag_x  <= ix;
      tag_y  <= iy;
      if (rd_vld) begin
        buf_q[tail] <= '{mvy:  bus.mem_rd_data[2*MV_W-1:MV_W],
                         mvx:  bus.mem_rd_data[MV_W-1:0],
                         bx:   tag_x,
                         by:   tag_y,
                         last: (tag_x == LAST_X) && (tag_y == LAST_Y)};
        tail <= ~tail;
      end
      if (pop) head <= ~head;
      occ <= pend[1:0];
    end
  end

  // Frame sequencing: address/coordinate walk, drain and completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      rd_ptr <= '0;
      ix     <= '0;
      iy     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start && rst_sync[1]) begin
            rd_ptr <= base_addr;
            ix     <= '0;
            iy     <= '0;
            busy   <= 1'b1;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (issue) begin
            rd_ptr <= rd_ptr + ADDR_W'(1);
            if (ix == LAST_X) begin
              ix <= '0;
              iy <= iy + CRD_W'(1);
            end else begin
              ix <= ix + CRD_W'(1);
            end
            if (last_tag) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (pend == 3'd0) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mv_fetch.sv
// Directed bench for mv_fetch: a 4x3 instance and a 1x1 instance, each with
// a 1-cycle-latency memory returning addr[7:0] as {mvy, mvx}.
module tb_mv_fetch;
  localparam int unsigned ADDR_W = 21;
  localparam int unsigned MV_W   = 4;
  localparam int unsigned CRD_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start_a, start_b;
  logic [ADDR_W-1:0] base_addr;
  logic              busy_a, done_a, busy_b, done_b;
  logic              ready;
  logic              sel;
  int                total = 0;
  int                bad   = 0;

  always #5 clk = ~clk;

  mv_fetch_if #(.ADDR_W(ADDR_W), .MV_W(MV_W), .CRD_W(CRD_W)) ia ();
  mv_fetch_if #(.ADDR_W(ADDR_W), .MV_W(MV_W), .CRD_W(CRD_W)) ib ();

  mv_fetch #(.ADDR_W(ADDR_W), .MV_W(MV_W), .BLK_COLS(4), .BLK_ROWS(3), .CRD_W(CRD_W)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .base_addr(base_addr),
    .busy(busy_a), .done(done_a), .bus(ia.master));

  mv_fetch #(.ADDR_W(ADDR_W), .MV_W(MV_W), .BLK_COLS(1), .BLK_ROWS(1), .CRD_W(CRD_W)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .base_addr(base_addr),
    .busy(busy_b), .done(done_b), .bus(ib.master));

  assign ia.out_ready = ready;
  assign ib.out_ready = ready;

  // Memory models: data is the low address byte, one cycle after the strobe.
  always @(posedge clk) begin
    if (ia.mem_rd_en) ia.mem_rd_data <= ia.mem_rd_addr[7:0];
    if (ib.mem_rd_en) ib.mem_rd_data <= ib.mem_rd_addr[7:0];
  end

  logic              c_en, c_valid, c_last, c_busy, c_done;
  logic [ADDR_W-1:0] c_addr;
  logic [31:0]       c_snap;

  always_comb begin
    c_en    = sel ? ib.mem_rd_en   : ia.mem_rd_en;
    c_addr  = sel ? ib.mem_rd_addr : ia.mem_rd_addr;
    c_valid = sel ? ib.out_valid   : ia.out_valid;
    c_last  = sel ? ib.out_last    : ia.out_last;
    c_busy  = sel ? busy_b : busy_a;
    c_done  = sel ? done_b : done_a;
    c_snap  = sel ? {6'd0, ib.out_valid, ib.out_mvy, ib.out_mvx, ib.out_bx, ib.out_by, ib.out_last}
                  : {6'd0, ia.out_valid, ia.out_mvy, ia.out_mvx, ia.out_bx, ia.out_by, ia.out_last};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // mode: 0 full rate, 1 ready pattern 1,0,0,1, 2 extra start mid-frame.
  // abort_after > 0 returns right after that many handshakes.
  task automatic run_frame(input logic s, input logic [ADDR_W-1:0] base,
                           input int cols, input int rows, input int mode,
                           input int abort_after);
    int                nvec = cols * rows;
    int                idx = 0, issued = 0, dones = 0, last_hs = -1, done_n = 0;
    int                first_v = -1, max_out = 0;
    logic              prev_stall = 1'b0;
    logic [31:0]       prev_snap = '0;
    logic [ADDR_W-1:0] a;
    logic [31:0]       exp_snap;
    logic [3:0]        pat = 4'b1001;
    sel       = s;
    base_addr = base;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (s) start_b = (n == 0); else start_a = (n == 0) || (mode == 2 && n == 5);
      base_addr = (mode == 2 && n == 5) ? ADDR_W'(32'h100) : base;
      ready = (mode == 1) ? pat[3 - (n % 4)] : 1'b1;
      #1;
      if (prev_stall) check("hold", c_snap, prev_snap);
      prev_stall = c_valid && !ready;
      prev_snap  = c_snap;
      check("busy", 32'(c_busy), 32'(n >= 1 && dones == 0 && !c_done));
      if (c_valid && first_v < 0) begin
        first_v = n;
        check("vld_lat", 32'(n), 32'd3);
      end
      if (c_en) begin
        if (issued == 0) check("rd_lat", 32'(n), 32'd1);
        check("rd_addr", 32'(c_addr), 32'(ADDR_W'(base + ADDR_W'(issued))));
        issued++;
      end
      if (c_valid && ready) begin
        a = ADDR_W'(base + ADDR_W'(idx));
        exp_snap = {6'd0, 1'b1, a[7:4], a[3:0], 8'(idx % cols), 8'(idx / cols), idx == nvec - 1};
        check("vec", c_snap, exp_snap);
        idx++;
        last_hs = n;
        if (abort_after > 0 && idx == abort_after) return;
      end
      if (issued - idx > max_out) max_out = issued - idx;
      if (c_done) begin
        dones++;
        done_n = n;
        check("done_at", 32'(n), 32'(last_hs + 1));
      end
      if (dones > 0 && n >= done_n + 2) break;
    end
    check("n_vec", 32'(idx), 32'(nvec));
    check("n_rd", 32'(issued), 32'(nvec));
    check("n_done", 32'(dones), 32'd1);
    check("max_out", 32'(max_out <= 2), 32'd1);
    if (mode == 0) check("last_hs", 32'(last_hs), 32'(nvec + 2));
  endtask

  initial begin
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; ready = 1'b1; sel = 1'b0;
    base_addr = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst", {27'd0, busy_a, done_a, ia.mem_rd_en, ia.out_valid, ia.out_last}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    run_frame(1'b0, '0, 4, 3, 0, 0);
    run_frame(1'b0, '0, 4, 3, 1, 0);
    run_frame(1'b0, ADDR_W'(32'h1FFFFE), 4, 3, 0, 0);
    run_frame(1'b0, '0, 4, 3, 2, 0);

    run_frame(1'b0, '0, 4, 3, 0, 5);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ctl", {27'd0, busy_a, done_a, ia.mem_rd_en, ia.out_valid, ia.out_last}, 32'd0);
    check("rst_mid_dat", c_snap, 32'd0);
    check("rst_mid_addr", 32'(ia.mem_rd_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    run_frame(1'b0, '0, 4, 3, 0, 0);

    run_frame(1'b1, ADDR_W'(32'h35), 1, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
